// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad up/down step controller.
// Contents: FSM state codes and a constant-evaluable ceil(log2) helper.
// No ports; imported by keypad_updown_ctrl and its debouncer.
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FIRE   = 3'd1,
    ST_HOLD   = 3'd2,
    ST_REPEAT = 3'd3,
    ST_LOCK   = 3'd4
  } ctrl_state_e;

  // Smallest w such that 2**w >= n (0 for n <= 1).
  function automatic int ceillog2(input int n);
    int w;
    w = 0;
    while ((longint'(1) << w) < longint'(n)) begin
      w = w + 1;
    end
    return w;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/keypad_updown_ctrl_debouncer.sv
// Purpose: debounce one raw pushbutton; output follows raw once raw has
//   disagreed with the current level for DEB_MAX consecutive cycles.
// Latency: DEB_MAX+1 cycles from a clean raw edge to level_o; no backpressure.
// Ports: clk, rst_a_p (async, active-high), raw_i (bouncing), level_o (debounced).
module keypad_updown_ctrl_debouncer
  import keypad_pkg::*;
#(
  parameter int DEB_MAX = 5000
) (
  input  logic clk,
  input  logic rst_a_p,
  input  logic raw_i,
  output logic level_o
);

  localparam int CW = (ceillog2(DEB_MAX) < 1) ? 1 : ceillog2(DEB_MAX);
  localparam logic [CW-1:0] TERM = CW'(DEB_MAX - 1);

  logic          raw_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst_a_p) begin
    if (rst_a_p) begin
      raw_q   <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      raw_q <= raw_i;
      // Any cycle where the sample agrees with the level restarts the window,
      // so a key bouncing faster than DEB_MAX never changes level.
      if (raw_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == TERM) begin
        level_q <= raw_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/keypad_updown_ctrl.sv
// Purpose: turn two bouncing up/down keys into count-enable strobes with
//   single-step on press, auto-repeat on hold and lockout when both are pressed.
// Latency: db_* rise in IDLE -> step_pulse 2 cycles later; no backpressure.
// Ports: clk, rst_a_p (async, active-high), key_up_raw/key_dn_raw (raw keys),
//   step_pulse (1-cycle strobe), dir_up (1=up), db_up/db_dn (synced debounced
//   levels), ctrl_state (FSM state code).
module keypad_updown_ctrl
  import keypad_pkg::*;
#(
  parameter int DEB_MAX      = 5000,
  parameter int HOLD_TICKS   = 25000000,
  parameter int REPEAT_TICKS = 5000000
) (
  input  logic       clk,
  input  logic       rst_a_p,
  input  logic       key_up_raw,
  input  logic       key_dn_raw,
  output logic       step_pulse,
  output logic       dir_up,
  output logic       db_up,
  output logic       db_dn,
  output logic [2:0] ctrl_state
);

  localparam int CNT_W_RAW = ceillog2(max2(HOLD_TICKS, REPEAT_TICKS));
  localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
  localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] REP_TERM  = CNT_W'(REPEAT_TICKS - 1);

  logic             up_deb;
  logic             dn_deb;
  logic [1:0]       up_sync_q;
  logic [1:0]       dn_sync_q;
  ctrl_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pulse_q;
  logic             dir_q;
  logic             own_key;
  logic             other_key;

  keypad_updown_ctrl_debouncer #(.DEB_MAX(DEB_MAX)) u_deb_up (
    .clk     (clk),
    .rst_a_p (rst_a_p),
    .raw_i   (key_up_raw),
    .level_o (up_deb)
  );

  keypad_updown_ctrl_debouncer #(.DEB_MAX(DEB_MAX)) u_deb_dn (
    .clk     (clk),
    .rst_a_p (rst_a_p),
    .raw_i   (key_dn_raw),
    .level_o (dn_deb)
  );

  always_ff @(posedge clk or posedge rst_a_p) begin
    if (rst_a_p) begin
      up_sync_q <= '0;
      dn_sync_q <= '0;
    end else begin
      up_sync_q <= {up_sync_q[0], up_deb};
      dn_sync_q <= {dn_sync_q[0], dn_deb};
    end
  end

  assign db_up = up_sync_q[1];
  assign db_dn = dn_sync_q[1];

  // dir_q doubles as the owner record: it is latched from db_up on the same
  // IDLE->FIRE edge that picks the owning key.
  assign own_key   = dir_q ? db_up : db_dn;
  assign other_key = dir_q ? db_dn : db_up;

  always_ff @(posedge clk or posedge rst_a_p) begin
    if (rst_a_p) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      dir_q   <= 1'b1;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (db_up && db_dn) begin
            state_q <= ST_LOCK;
          end else if (db_up ^ db_dn) begin
            state_q <= ST_FIRE;
            dir_q   <= db_up;
          end
        end
        ST_FIRE: begin
          state_q <= ST_HOLD;
          cnt_q   <= '0;
          pulse_q <= 1'b1;
        end
        ST_HOLD: begin
          // Abort checks come before the terminal count so a release or a
          // second key on the terminal cycle never produces a pulse.
          if (other_key) begin
            state_q <= ST_LOCK;
            cnt_q   <= '0;
          end else if (!own_key) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == HOLD_TERM) begin
            state_q <= ST_REPEAT;
            cnt_q   <= '0;
            pulse_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (other_key) begin
            state_q <= ST_LOCK;
            cnt_q   <= '0;
          end else if (!own_key) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == REP_TERM) begin
            cnt_q   <= '0;
            pulse_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_LOCK: begin
          cnt_q <= '0;
          if (!db_up && !db_dn) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign step_pulse = pulse_q;
  assign dir_up     = dir_q;
  assign ctrl_state = state_q;

endmodule

// File: tb/tb_keypad_updown_ctrl.sv
// Directed bench for keypad_updown_ctrl with DEB_MAX=4, HOLD_TICKS=8,
// REPEAT_TICKS=3: table-driven press/hold/repeat timeline plus hand-written
// sequences for tap, bounce rejection, lockout, late second key and reset.
module tb_keypad_updown_ctrl;

  logic       clk = 1'b0;
  logic       rst_a_p = 1'b0;
  logic       key_up_raw = 1'b0;
  logic       key_dn_raw = 1'b0;
  logic       step_pulse;
  logic       dir_up;
  logic       db_up;
  logic       db_dn;
  logic [2:0] ctrl_state;

  always #5 clk = ~clk;

  keypad_updown_ctrl #(
    .DEB_MAX      (4),
    .HOLD_TICKS   (8),
    .REPEAT_TICKS (3)
  ) dut (
    .clk        (clk),
    .rst_a_p    (rst_a_p),
    .key_up_raw (key_up_raw),
    .key_dn_raw (key_dn_raw),
    .step_pulse (step_pulse),
    .dir_up     (dir_up),
    .db_up      (db_up),
    .db_dn      (db_dn),
    .ctrl_state (ctrl_state)
  );

  typedef struct {
    logic       pulse;
    logic [2:0] st;
    logic       dir;
  } vec_t;

  vec_t tbl [17];

  int   n_chk = 0;
  int   n_pass = 0;
  int   pulses = 0;
  int   up_pulses = 0;
  int   dn_pulses = 0;
  int   consec = 0;
  logic prev_pulse = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Advance to the next falling edge and account for any strobe seen there.
  task automatic step();
    @(negedge clk);
    if (step_pulse) begin
      pulses++;
      if (dir_up) up_pulses++;
      else dn_pulses++;
      if (prev_pulse) consec++;
    end
    prev_pulse = step_pulse;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_lvl(input int which, input logic lvl, input string name);
    int   n;
    logic s;
    n = 0;
    s = (which == 0) ? db_up : db_dn;
    while (s !== lvl && n < 40) begin
      step();
      n++;
      s = (which == 0) ? db_up : db_dn;
    end
    chk(name, int'(s), int'(lvl));
  endtask

  initial begin
    int snap;
    int snap_up;
    int snap_dn;
    int hi;
    logic seen;

    // k = cycles after db_up rises while up is held cleanly
    tbl = '{
      '{1'b0, 3'd0, 1'b1}, '{1'b0, 3'd1, 1'b1}, '{1'b1, 3'd2, 1'b1},
      '{1'b0, 3'd2, 1'b1}, '{1'b0, 3'd2, 1'b1}, '{1'b0, 3'd2, 1'b1},
      '{1'b0, 3'd2, 1'b1}, '{1'b0, 3'd2, 1'b1}, '{1'b0, 3'd2, 1'b1},
      '{1'b0, 3'd2, 1'b1}, '{1'b1, 3'd3, 1'b1}, '{1'b0, 3'd3, 1'b1},
      '{1'b0, 3'd3, 1'b1}, '{1'b1, 3'd3, 1'b1}, '{1'b0, 3'd3, 1'b1},
      '{1'b0, 3'd3, 1'b1}, '{1'b1, 3'd3, 1'b1}
    };

    // Reset state
    #2 rst_a_p = 1'b1;
    #1;
    chk("rst_pulse", int'(step_pulse), 0);
    chk("rst_state", int'(ctrl_state), 0);
    chk("rst_dir", int'(dir_up), 1);
    chk("rst_db", int'({db_up, db_dn}), 0);
    steps(3);
    rst_a_p = 1'b0;
    steps(2);
    chk("idle_state", int'(ctrl_state), 0);

    // Up held: FIRE, HOLD, REPEAT timeline
    key_up_raw = 1'b1;
    wait_lvl(0, 1'b1, "up_db_rise");
    for (int k = 0; k < 17; k++) begin
      if (k > 0) step();
      chk($sformatf("up_k%0d_pulse", k), int'(step_pulse), int'(tbl[k].pulse));
      chk($sformatf("up_k%0d_state", k), int'(ctrl_state), int'(tbl[k].st));
      chk($sformatf("up_k%0d_dir", k), int'(dir_up), int'(tbl[k].dir));
    end
    steps(17);
    key_up_raw = 1'b0;
    wait_lvl(0, 1'b0, "up_db_fall");
    snap = pulses;
    steps(3);
    chk("up_release_nopulse", pulses, snap);
    chk("up_release_idle", int'(ctrl_state), 0);

    // Down tap: one pulse, dir down, back to IDLE
    snap = pulses;
    snap_dn = dn_pulses;
    key_dn_raw = 1'b1;
    steps(6);
    key_dn_raw = 1'b0;
    wait_lvl(1, 1'b1, "tap_db_rise");
    hi = 0;
    while (db_dn && hi < 40) begin
      step();
      hi++;
    end
    chk("tap_db_len", hi, 6);
    steps(3);
    chk("tap_pulses", pulses - snap, 1);
    chk("tap_dn_pulses", dn_pulses - snap_dn, 1);
    chk("tap_idle", int'(ctrl_state), 0);
    chk("tap_dir", int'(dir_up), 0);

    // Bouncing up key: toggles every cycle, never debounced
    snap = pulses;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      key_up_raw = ~key_up_raw;
      step();
      if (db_up) seen = 1'b1;
    end
    key_up_raw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (db_up) seen = 1'b1;
    end
    chk("bounce_db", int'(seen), 0);
    chk("bounce_pulses", pulses - snap, 0);
    chk("bounce_idle", int'(ctrl_state), 0);

    // Both keys in the same cycle: LOCK until both released
    snap = pulses;
    key_up_raw = 1'b1;
    key_dn_raw = 1'b1;
    wait_lvl(0, 1'b1, "lock_db_up");
    chk("lock_db_dn", int'(db_dn), 1);
    step();
    chk("lock_state", int'(ctrl_state), 4);
    steps(3);
    chk("lock_dir_kept", int'(dir_up), 0);
    key_up_raw = 1'b0;
    wait_lvl(0, 1'b0, "lock_up_fall");
    steps(3);
    chk("lock_up_only", int'(ctrl_state), 4);
    key_dn_raw = 1'b0;
    wait_lvl(1, 1'b0, "lock_dn_fall");
    step();
    chk("lock_exit_idle", int'(ctrl_state), 0);
    chk("lock_pulses", pulses - snap, 0);

    // Up into REPEAT, then down pressed: LOCK, no more pulses
    snap = pulses;
    snap_up = up_pulses;
    key_up_raw = 1'b1;
    wait_lvl(0, 1'b1, "rl_db_up");
    steps(12);
    chk("rl_repeat", int'(ctrl_state), 3);
    chk("rl_pulses", pulses - snap, 2);
    chk("rl_up_pulses", up_pulses - snap_up, 2);
    key_dn_raw = 1'b1;
    wait_lvl(1, 1'b1, "rl_db_dn");
    snap = pulses;
    step();
    chk("rl_lock", int'(ctrl_state), 4);
    steps(10);
    chk("rl_nopulse", pulses, snap);
    key_up_raw = 1'b0;
    key_dn_raw = 1'b0;
    wait_lvl(0, 1'b0, "rl_up_fall");
    wait_lvl(1, 1'b0, "rl_dn_fall");
    step();
    chk("rl_idle", int'(ctrl_state), 0);

    // Reset mid-REPEAT with up still held
    key_up_raw = 1'b1;
    wait_lvl(0, 1'b1, "rr_db_up");
    steps(12);
    chk("rr_repeat", int'(ctrl_state), 3);
    rst_a_p = 1'b1;
    #1;
    chk("rr_pulse0", int'(step_pulse), 0);
    chk("rr_state0", int'(ctrl_state), 0);
    chk("rr_dir1", int'(dir_up), 1);
    chk("rr_db0", int'(db_up), 0);
    snap = pulses;
    steps(2);
    rst_a_p = 1'b0;
    wait_lvl(0, 1'b1, "rr_db_rerise");
    chk("rr_no_pulse", pulses, snap);
    step();
    chk("rr_fire", int'(ctrl_state), 1);
    step();
    chk("rr_fire_pulse", int'(step_pulse), 1);
    chk("rr_fire_dir", int'(dir_up), 1);
    key_up_raw = 1'b0;
    wait_lvl(0, 1'b0, "rr_db_fall");
    steps(2);

    chk("no_back_to_back", consec, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
